// File: rtl/maxnet_pkg.sv
// Shared definitions for the MAXNET winner-take-all engine: FSM states and
// default parameter values.
package maxnet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 32;
  localparam int DEF_EPS_SHIFT = 3;
  localparam int DEF_MAX_ITER  = 255;

endpackage

// File: rtl/maxnet_pe.sv
// One MAXNET channel update: subtract eps times the sum of all other
// activations, flooring the result at zero.
module maxnet_pe #(
  parameter int W         = 32,
  parameter int EPS_SHIFT = 3,
  parameter int TOTAL_W   = W + 2
) (
  input  logic [W-1:0]       a_i,
  input  logic [TOTAL_W-1:0] total,
  output logic [W-1:0]       a_next
);

  logic [TOTAL_W-1:0] dec;

  // total always includes a_i, so the difference cannot underflow
  assign dec    = (total - TOTAL_W'(a_i)) >> EPS_SHIFT;
  assign a_next = (TOTAL_W'(a_i) > dec) ? (a_i - dec[W-1:0]) : '0;

endmodule

// File: rtl/maxnet_engine.sv
// MAXNET competition engine: iterates mutual inhibition until one channel
// survives, all die, or MAX_ITER updates elapse. Optional MAXNET_ITER_COUNT_EN
// adds an iter_count output reporting the number of updates performed.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int EPS_SHIFT = DEF_EPS_SHIFT,
  parameter int MAX_ITER  = DEF_MAX_ITER
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*W-1:0]       x_in,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic [W-1:0]         winner_val,
  output logic                 no_winner,
  output logic                 timeout
`ifdef MAXNET_ITER_COUNT_EN
  ,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
`endif
);

  localparam int IW   = $clog2(N);
  localparam int ITW  = $clog2(MAX_ITER + 1);
  localparam int TW   = W + $clog2(N);
  localparam int CNTW = $clog2(N + 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg [N];
  logic [W-1:0]   a_next [N];
  logic [W-1:0]   a_upd [N];
  logic [W-1:0]   x_reg [N];
  logic [W-1:0]   x_next [N];
  logic [W-1:0]   x_ch [N];
  logic [ITW-1:0] iter_reg, iter_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [W-1:0]   val_reg, val_next;
  logic           nowin_reg, nowin_next;
  logic           tmo_reg, tmo_next;
`ifdef MAXNET_ITER_COUNT_EN
  logic [ITW-1:0] icnt_reg, icnt_next;
`endif

  logic [TW-1:0]   total;
  logic [CNTW-1:0] nz_cnt;
  logic [IW-1:0]   low_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign x_ch[gi] = x_in[gi*W +: W];

      maxnet_pe #(
        .W         (W),
        .EPS_SHIFT (EPS_SHIFT),
        .TOTAL_W   (TW)
      ) u_pe (
        .a_i    (a_reg[gi]),
        .total  (total),
        .a_next (a_upd[gi])
      );
    end
  endgenerate

  // Survivor census over the current activations; low_idx is the
  // lowest-index nonzero channel (the sole survivor when nz_cnt==1).
  always_comb begin
    total   = '0;
    nz_cnt  = '0;
    low_idx = '0;
    for (int i = 0; i < N; i++) begin
      total = total + TW'(a_reg[i]);
      if (a_reg[i] != '0) nz_cnt = nz_cnt + CNTW'(1);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (a_reg[i] != '0) low_idx = IW'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    x_next     = x_reg;
    iter_next  = iter_reg;
    idx_next   = idx_reg;
    val_next   = val_reg;
    nowin_next = nowin_reg;
    tmo_next   = tmo_reg;
`ifdef MAXNET_ITER_COUNT_EN
    icnt_next  = icnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_next     = x_ch;
          x_next     = x_ch;
          iter_next  = '0;
          nowin_next = 1'b0;
          tmo_next   = 1'b0;
          state_next = ST_ITER;
        end
      end
      ST_ITER: begin
        if (nz_cnt == '0) begin
          nowin_next = 1'b1;
          idx_next   = '0;
          val_next   = '0;
          state_next = ST_DONE;
        end else if (nz_cnt == CNTW'(1)) begin
          idx_next   = low_idx;
          val_next   = x_reg[low_idx];
          state_next = ST_DONE;
        end else if (iter_reg == ITW'(MAX_ITER)) begin
          tmo_next   = 1'b1;
          idx_next   = low_idx;
          val_next   = x_reg[low_idx];
          state_next = ST_DONE;
        end else begin
          a_next    = a_upd;
          iter_next = iter_reg + ITW'(1);
        end
`ifdef MAXNET_ITER_COUNT_EN
        if (state_next == ST_DONE) icnt_next = iter_reg;
`endif
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      for (int i = 0; i < N; i++) begin
        a_reg[i] <= '0;
        x_reg[i] <= '0;
      end
      iter_reg  <= '0;
      idx_reg   <= '0;
      val_reg   <= '0;
      nowin_reg <= 1'b0;
      tmo_reg   <= 1'b0;
`ifdef MAXNET_ITER_COUNT_EN
      icnt_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      x_reg     <= x_next;
      iter_reg  <= iter_next;
      idx_reg   <= idx_next;
      val_reg   <= val_next;
      nowin_reg <= nowin_next;
      tmo_reg   <= tmo_next;
`ifdef MAXNET_ITER_COUNT_EN
      icnt_reg  <= icnt_next;
`endif
    end
  end

  assign busy       = (state_reg == ST_ITER);
  assign done       = (state_reg == ST_DONE);
  assign winner_idx = idx_reg;
  assign winner_val = val_reg;
  assign no_winner  = nowin_reg;
  assign timeout    = tmo_reg;
`ifdef MAXNET_ITER_COUNT_EN
  assign iter_count = icnt_reg;
`endif

endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine: directed corner cases plus random
// competitions compared against an arithmetic reference model.
module tb_maxnet_engine;

  localparam int N         = 4;
  localparam int W         = 32;
  localparam int EPS_SHIFT = 3;
  localparam int MAX_ITER  = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N*W-1:0] x_in;
  logic           busy;
  logic           done;
  logic [1:0]     winner_idx;
  logic [W-1:0]   winner_val;
  logic           no_winner;
  logic           timeout;
`ifdef MAXNET_ITER_COUNT_EN
  logic [7:0]     iter_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  maxnet_engine #(
    .N         (N),
    .W         (W),
    .EPS_SHIFT (EPS_SHIFT),
    .MAX_ITER  (MAX_ITER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x_in       (x_in),
    .busy       (busy),
    .done       (done),
    .winner_idx (winner_idx),
    .winner_val (winner_val),
    .no_winner  (no_winner),
    .timeout    (timeout)
`ifdef MAXNET_ITER_COUNT_EN
    ,
    .iter_count (iter_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [31:0] v0, input logic [31:0] v1,
                                           input logic [31:0] v2, input logic [31:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // Reference: run the inhibition rule directly on integers.
  task automatic model(input logic [N*W-1:0] xv, output int idx, output longint val,
                       output bit nw, output bit to, output int k);
    longint a [N];
    longint na [N];
    longint tot;
    int nz;
    int first;
    for (int i = 0; i < N; i++) a[i] = longint'(xv[i*W +: W]);
    k = 0; nw = 0; to = 0; idx = 0;
    while (1) begin
      nz = 0; first = -1;
      for (int i = 0; i < N; i++) if (a[i] != 0) begin
        nz++;
        if (first < 0) first = i;
      end
      if (nz == 1) begin idx = first; break; end
      if (nz == 0) begin nw = 1; idx = 0; break; end
      if (k == MAX_ITER) begin to = 1; idx = first; break; end
      tot = 0;
      for (int i = 0; i < N; i++) tot += a[i];
      for (int i = 0; i < N; i++) begin
        longint d = (tot - a[i]) / (longint'(1) << EPS_SHIFT);
        na[i] = (a[i] > d) ? a[i] - d : 0;
      end
      a = na;
      k++;
    end
    val = nw ? 0 : longint'(xv[idx*W +: W]);
  endtask

  task automatic run_case(input string name, input logic [N*W-1:0] xv, input int pulse_at);
    int e_idx, e_k, cyc;
    longint e_val;
    bit e_nw, e_to;
    model(xv, e_idx, e_val, e_nw, e_to, e_k);
    @(negedge clk);
    start = 1'b1;
    x_in  = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc   = 1;
    check($sformatf("%s busy", name), 64'(busy), 64'd1);
    while (!done && cyc < MAX_ITER + 10) begin
      if (cyc == pulse_at) begin
        start = 1'b1;
        x_in  = pack4(32'd1, 32'd0, 32'd0, 32'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check($sformatf("%s done_seen", name), 64'(done), 64'd1);
    check($sformatf("%s latency", name), 64'(cyc), 64'(e_k + 2));
    check($sformatf("%s winner_idx", name), 64'(winner_idx), 64'(e_idx));
    check($sformatf("%s winner_val", name), 64'(winner_val), 64'(e_val));
    check($sformatf("%s no_winner", name), 64'(no_winner), 64'(e_nw));
    check($sformatf("%s timeout", name), 64'(timeout), 64'(e_to));
`ifdef MAXNET_ITER_COUNT_EN
    check($sformatf("%s iter_count", name), 64'(iter_count), 64'(e_k));
`endif
    @(posedge clk);
    #1;
    check($sformatf("%s done_pulse", name), 64'(done), 64'd0);
    check($sformatf("%s idx_held", name), 64'(winner_idx), 64'(e_idx));
    check($sformatf("%s val_held", name), 64'(winner_val), 64'(e_val));
    $display("[TB] %s x=%h updates=%0d idx=%0d val=%0d nw=%0d to=%0d",
             name, xv, e_k, winner_idx, winner_val, no_winner, timeout);
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s busy", name), 64'(busy), 64'd0);
    check($sformatf("%s done", name), 64'(done), 64'd0);
    check($sformatf("%s winner_idx", name), 64'(winner_idx), 64'd0);
    check($sformatf("%s winner_val", name), 64'(winner_val), 64'd0);
    check($sformatf("%s no_winner", name), 64'(no_winner), 64'd0);
    check($sformatf("%s timeout", name), 64'(timeout), 64'd0);
`ifdef MAXNET_ITER_COUNT_EN
    check($sformatf("%s iter_count", name), 64'(iter_count), 64'd0);
`endif
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [N];
    int mode;
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_case("ramp", pack4(32'd8, 32'd16, 32'd32, 32'd64), -1);
    run_case("all_zero", pack4(32'd0, 32'd0, 32'd0, 32'd0), -1);
    run_case("single", pack4(32'd0, 32'd0, 32'd9, 32'd0), -1);
    run_case("tie_stall", pack4(32'd50, 32'd50, 32'd0, 32'd0), -1);
    run_case("start_in_iter", pack4(32'd8, 32'd16, 32'd32, 32'd64), 2);

    // Abandon a competition with reset mid-ITER
    @(negedge clk);
    start = 1'b1;
    x_in  = pack4(32'd8, 32'd16, 32'd32, 32'd64);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mid_reset no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    run_case("after_reset", pack4(32'd8, 32'd16, 32'd32, 32'd64), -1);

    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: v[i] = $urandom_range(0, 100);
          1: v[i] = $urandom();
          2: v[i] = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom_range(1, 5000);
          default: v[i] = ($urandom_range(0, 1) == 0) ? 32'd200 : $urandom_range(0, 30);
        endcase
      end
      run_case($sformatf("rand%0d", t), pack4(v[0], v[1], v[2], v[3]),
               ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
